axi_burst_sram: RTL and testbench
=================================

AXI_BURST_SRAM -- requirements
Module: axi_burst_sram

Interface
REQ-001 The module SHALL have parameter MEM_WORDS, default 1024, giving the memory depth in AXI_DATA_WIDTH-bit words; it must be a power of two.
REQ-002 The module SHALL have parameter DATA_WIDTH, default `AXI_DATA_WIDTH (32), giving the data bus width.
REQ-003 The module SHALL have one clock; reset is synchronous and active-high; ports:
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- m_awaddr  in  32  write burst byte address
- m_awlen  in  8  write beats minus one
- m_awvalid  in  1  write address valid
- s_awready  out  1  write address accepted
- m_wdata  in  DATA_WIDTH  write beat data
- m_wlast  in  1  final write beat marker (informational)
- m_wvalid  in  1  write data valid
- s_wready  out  1  write data accepted
- s_bvalid  out  1  write response valid
- m_bready  in  1  write response accepted
- m_araddr  in  32  read burst byte address
- m_arlen  in  8  read beats minus one
- m_arvalid  in  1  read address valid
- s_arready  out  1  read address accepted
- s_rdata  out  DATA_WIDTH  read beat data
- s_rvalid  out  1  read data valid
- m_rready  in  1  read data accepted
REQ-004 The port set SHALL match the slave modport of the AXI4 interface one-to-one; m_awprot/m_arprot are present but ignored.

Function
REQ-005 The module SHALL implement states IDLE, WRITE_BURST, WRITE_RESP, READ_BURST.
REQ-006 In IDLE, the module SHALL assert s_awready or s_arready (never both) for the granted channel only, combinationally from the valids.
REQ-007 Arbitration when both valids are high SHALL be round-robin: grant the channel not granted last; write wins on the first conflict after reset.
REQ-008 On the AW handshake, the module SHALL latch word index m_awaddr[2 +: log2(MEM_WORDS)] and count m_awlen, then go to WRITE_BURST next cycle.
REQ-009 In WRITE_BURST, s_wready SHALL be 1; each wvalid&wready cycle writes m_wdata to mem[index], increments index modulo MEM_WORDS, and decrements count.
REQ-010 The beat accepted with count==0 SHALL end the burst; m_wlast is ignored; the next state is WRITE_RESP.
REQ-011 In WRITE_RESP, s_bvalid SHALL be 1 until m_bready, then return to IDLE the following cycle.
REQ-012 On the AR handshake in cycle N, the module SHALL latch index/count, enter READ_BURST, and present the first beat with s_rvalid=1 in cycle N+2 (one-cycle synchronous RAM read).
REQ-013 With m_rready held high, the module SHALL deliver one beat per cycle with no bubbles after the first.
REQ-014 While s_rvalid=1 and m_rready=0, s_rdata and s_rvalid SHALL remain stable.
REQ-015 After the beat with count==0 is accepted, s_rvalid SHALL drop next cycle and the state SHALL return to IDLE.
REQ-016 Address wrap: index MEM_WORDS-1 increments to 0; upper address bits and bits [1:0] SHALL be ignored.
REQ-017 A read of a word written by an earlier completed burst (B handshake done) SHALL return the new data.
REQ-018 Concurrent AW and AR transactions SHALL NOT overlap; the non-granted channel waits in IDLE.

Reset
REQ-019 While reset=1, the module SHALL hold state=IDLE, s_awready=0, s_arready=0, s_wready=0, s_bvalid=0, s_rvalid=0, s_rdata=0, with the last grant set to read (so write wins first).
REQ-020 Reset asserted mid-burst SHALL abandon the burst without further memory writes; memory contents SHALL NOT be cleared.

Verification
REQ-021 Single write: AW addr 0x10 len 0, W 0xDEADBEEF -> mem[4]=0xDEADBEEF, one-cycle s_bvalid pulse with bready=1.
REQ-022 Read burst: AR addr 0x0 len 3 after writing 1,2,3,4 at 0x0 -> rdata 1,2,3,4 on consecutive cycles starting N+2.
REQ-023 Backpressure: read len 1, m_rready low for 3 cycles on beat 0 -> rdata held constant, exactly 2 beats delivered.
REQ-024 Wrap: MEM_WORDS=1024, write addr 0xFFC len 1, data A,B -> mem[1023]=A, mem[0]=B.
REQ-025 Arbitration: awvalid and arvalid held together for three transactions -> grant order write, read, write.
REQ-026 Reset mid write burst after 2 of 4 beats -> outputs at reset values next cycle, only first 2 words changed, new AW accepted afterward.

Source files
------------

// File: rtl/axi_burst_sram.sv
// axi_burst_sram: AXI4 burst slave over a synchronous word SRAM with round-robin AW/AR arbitration
module axi_burst_sram #(
  parameter int MEM_WORDS = 1024,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           m_awaddr,
  input  logic [7:0]            m_awlen,
  input  logic [2:0]            m_awprot,
  input  logic                  m_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_wlast,
  input  logic                  m_wvalid,
  output logic                  s_wready,
  output logic                  s_bvalid,
  input  logic                  m_bready,
  input  logic [31:0]           m_araddr,
  input  logic [7:0]            m_arlen,
  input  logic [2:0]            m_arprot,
  input  logic                  m_arvalid,
  output logic                  s_arready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  s_rvalid,
  input  logic                  m_rready
);
  localparam int IW = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {IDLE, WRITE_BURST, WRITE_RESP, READ_BURST} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [IW-1:0] idx;
  logic [7:0] cnt;
  logic fetching, last_wr, grant_w, aw_hs, ar_hs, w_hs, r_adv;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_wr <= 1'b0;
      fetching <= 1'b0;
      idx <= '0;
      cnt <= '0;
      s_rvalid <= 1'b0;
      s_rdata <= '0;
    end else begin
      state <= state_nx;
      if (aw_hs || ar_hs) begin
        idx <= aw_hs ? m_awaddr[2 +: IW] : m_araddr[2 +: IW];
        cnt <= aw_hs ? m_awlen : m_arlen;
        last_wr <= aw_hs;
        fetching <= ar_hs;
      end else if (w_hs || (r_adv && fetching)) begin
        idx <= idx + 1'b1;
        cnt <= cnt - 1'b1;
        fetching <= fetching && cnt != 8'd0;
      end
      // the output register refills whenever it is empty or being drained
      if (r_adv) begin
        s_rvalid <= fetching;
        s_rdata <= fetching ? mem[idx] : s_rdata;
      end
    end
  end
  always_ff @(posedge clk)
    if (w_hs)
      mem[idx] <= m_wdata;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        state_nx = aw_hs ? WRITE_BURST : ar_hs ? READ_BURST : IDLE;
      WRITE_BURST: state_nx = (w_hs && cnt == 8'd0) ? WRITE_RESP : WRITE_BURST;
      WRITE_RESP:  state_nx = m_bready ? IDLE : WRITE_RESP;
      READ_BURST:  state_nx = (!fetching && s_rvalid && m_rready) ? IDLE : READ_BURST;
      default:     state_nx = IDLE;
    endcase
  end
  always_comb begin
    grant_w = m_awvalid && (!m_arvalid || !last_wr);
    s_awready = !reset && state == IDLE && grant_w;
    s_arready = !reset && state == IDLE && m_arvalid && !grant_w;
    s_wready = !reset && state == WRITE_BURST;
    s_bvalid = !reset && state == WRITE_RESP;
    aw_hs = s_awready;
    ar_hs = s_arready;
    w_hs = s_wready && m_wvalid;
    r_adv = state == READ_BURST && (!s_rvalid || m_rready);
  end
endmodule

// File: tb/tb_axi_burst_sram.sv
// tb_axi_burst_sram: directed bursts with queued expectations checked by a negedge monitor
module tb_axi_burst_sram;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] m_awaddr = '0, m_araddr = '0, m_wdata = '0, s_rdata;
  logic [7:0] m_awlen = '0, m_arlen = '0;
  logic m_awvalid = 1'b0, m_arvalid = 1'b0, m_wvalid = 1'b0, m_wlast = 1'b0;
  logic m_bready = 1'b1, m_rready = 1'b1;
  logic s_awready, s_arready, s_wready, s_bvalid, s_rvalid;
  int n_chk = 0, n_fail = 0;
  logic [31:0] rq [$];
  logic gq [$];
  int bq [$];
  logic [31:0] wbuf [8];
  logic [31:0] ebuf [8];
  axi_burst_sram dut (
    .clk(clk), .reset(reset),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awprot(3'b000), .m_awvalid(m_awvalid), .s_awready(s_awready),
    .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arprot(3'b000), .m_arvalid(m_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .m_rready(m_rready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, wanted %h", nm, act, exp);
    end
  endtask
  task automatic bad(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event seen with nothing expected", nm);
  endtask
  function automatic logic sig(input int k);
    return k == 0 ? s_awready : k == 1 ? s_arready : k == 2 ? s_wready : k == 3 ? s_bvalid : s_rvalid;
  endfunction
  task automatic wait_for(input int k, input string nm);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sig(k)) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL timeout_%s: got no handshake, wanted one within 60 cycles", nm);
  endtask
  always @(negedge clk) if (!reset) begin
    chk("one_grant", {31'd0, s_awready && s_arready}, 32'd0);
    if (s_awready || s_arready) begin
      if (gq.size() == 0) bad("grant");
      else chk("grant_is_write", {31'd0, s_awready}, {31'd0, gq.pop_front()});
    end
    if (s_rvalid && m_rready) begin
      if (rq.size() == 0) bad("rbeat");
      else chk("rdata", s_rdata, rq.pop_front());
    end
    if (s_bvalid && m_bready) begin
      if (bq.size() == 0) bad("bresp");
      else void'(bq.pop_front());
    end
  end
  task automatic do_write(input logic [31:0] addr, input int len, input bit push_grant);
    if (push_grant) gq.push_back(1'b1);
    m_awaddr = addr;
    m_awlen = 8'(len);
    m_awvalid = 1'b1;
    wait_for(0, "aw");
    @(posedge clk); #1;
    m_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      m_wdata = wbuf[i];
      m_wvalid = 1'b1;
      m_wlast = i == len;
      wait_for(2, "w");
      @(posedge clk); #1;
    end
    m_wvalid = 1'b0;
    m_wlast = 1'b0;
    bq.push_back(1);
    wait_for(3, "b");
    @(posedge clk); #1;
    chk("bvalid_pulse", {31'd0, s_bvalid}, 32'd0);
  endtask
  task automatic do_read(input logic [31:0] addr, input int len, input bit stall, input bit push_grant);
    logic [31:0] held;
    if (push_grant) gq.push_back(1'b0);
    for (int i = 0; i <= len; i++) rq.push_back(ebuf[i]);
    m_araddr = addr;
    m_arlen = 8'(len);
    m_arvalid = 1'b1;
    m_rready = !stall;
    wait_for(1, "ar");
    @(posedge clk); #1;
    m_arvalid = 1'b0;
    @(negedge clk);
    chk("rvalid_n1", {31'd0, s_rvalid}, 32'd0);
    if (stall) begin
      @(negedge clk);
      held = s_rdata;
      chk("stall_rdata0", s_rdata, ebuf[0]);
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        chk("stall_rvalid", {31'd0, s_rvalid}, 32'd1);
        chk("stall_hold", s_rdata, held);
      end
      @(posedge clk); #1;
      m_rready = 1'b1;
      for (int i = 0; i < 20 && (rq.size() != 0 || s_rvalid); i++) @(negedge clk);
      chk("beats_left", rq.size(), 32'd0);
    end else begin
      for (int i = 0; i <= len; i++) begin
        @(negedge clk);
        chk("rvalid_beat", {31'd0, s_rvalid}, 32'd1);
      end
      @(negedge clk);
      chk("rvalid_drop", {31'd0, s_rvalid}, 32'd0);
    end
    @(posedge clk); #1;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, wanted finish");
    $fatal(1, "watchdog");
  end
  initial begin
    m_awvalid = 1'b1;
    m_arvalid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", {31'd0, s_awready}, 32'd0);
    chk("rst_arready", {31'd0, s_arready}, 32'd0);
    chk("rst_wready", {31'd0, s_wready}, 32'd0);
    chk("rst_bvalid", {31'd0, s_bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, s_rvalid}, 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_awvalid = 1'b0;
    m_arvalid = 1'b0;
    wbuf[0] = 32'hDEADBEEF;
    do_write(32'h10, 0, 1'b1);
    ebuf[0] = 32'hDEADBEEF;
    do_read(32'h10, 0, 1'b0, 1'b1);
    do_read(32'hFFFF_F013, 0, 1'b0, 1'b1);
    wbuf[0] = 1; wbuf[1] = 2; wbuf[2] = 3; wbuf[3] = 4;
    do_write(32'h0, 3, 1'b1);
    ebuf[0] = 1; ebuf[1] = 2; ebuf[2] = 3; ebuf[3] = 4;
    do_read(32'h0, 3, 1'b0, 1'b1);
    ebuf[0] = 1; ebuf[1] = 2;
    do_read(32'h0, 1, 1'b1, 1'b1);
    wbuf[0] = 32'hAAAA0001; wbuf[1] = 32'hBBBB0002;
    do_write(32'hFFC, 1, 1'b1);
    ebuf[0] = 32'hAAAA0001; ebuf[1] = 32'hBBBB0002;
    do_read(32'hFFC, 1, 1'b0, 1'b1);
    ebuf[0] = 32'hBBBB0002; ebuf[1] = 2;
    do_read(32'h0, 1, 1'b0, 1'b1);
    gq.push_back(1'b1); gq.push_back(1'b0); gq.push_back(1'b1);
    fork
      begin
        wbuf[0] = 32'h11;
        do_write(32'h40, 0, 1'b0);
        wbuf[0] = 32'h22;
        do_write(32'h44, 0, 1'b0);
      end
      begin
        ebuf[0] = 32'h11;
        do_read(32'h40, 0, 1'b0, 1'b0);
      end
    join
    ebuf[0] = 32'h11; ebuf[1] = 32'h22;
    do_read(32'h40, 1, 1'b0, 1'b1);
    wbuf[0] = 32'hC0; wbuf[1] = 32'hC1; wbuf[2] = 32'hC2; wbuf[3] = 32'hC3;
    do_write(32'h80, 3, 1'b1);
    gq.push_back(1'b1);
    m_awaddr = 32'h80;
    m_awlen = 8'd3;
    m_awvalid = 1'b1;
    wait_for(0, "aw_rst");
    @(posedge clk); #1;
    m_awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_wdata = 32'(5 + i);
      m_wvalid = 1'b1;
      wait_for(2, "w_rst");
      @(posedge clk); #1;
    end
    m_wdata = 32'h7;
    m_awvalid = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_awready", {31'd0, s_awready}, 32'd0);
    chk("mid_wready", {31'd0, s_wready}, 32'd0);
    chk("mid_bvalid", {31'd0, s_bvalid}, 32'd0);
    chk("mid_rvalid", {31'd0, s_rvalid}, 32'd0);
    chk("mid_rdata", s_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_wvalid = 1'b0;
    m_awvalid = 1'b0;
    wbuf[0] = 32'h99;
    do_write(32'h100, 0, 1'b1);
    ebuf[0] = 5; ebuf[1] = 6; ebuf[2] = 32'hC2; ebuf[3] = 32'hC3;
    do_read(32'h80, 3, 1'b0, 1'b1);
    ebuf[0] = 32'h99;
    do_read(32'h100, 0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rq_empty", rq.size(), 32'd0);
    chk("bq_empty", bq.size(), 32'd0);
    chk("gq_empty", gq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
